// File: rtl/print_arb_pkg.sv
// Shared definitions for the print arbiter.
//   NREQ_DEFAULT    - default number of message requesters
//   TIMEOUT_DEFAULT - default idle cycles before a granted requester is forced off
//   CNT_W           - width of the idle-timeout counter
//   arb_state_e     - arbiter FSM states
package print_arb_pkg;

    localparam int unsigned NREQ_DEFAULT    = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 65535;
    localparam int unsigned CNT_W           = 17;

    typedef enum logic [1:0] {
        StIdle,
        StLock,
        StDrain
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i   - request vector
//   ptr_i   - index where the search starts (wraps N-1 -> 0)
//   pick_o  - one-hot of the first requester at or after ptr_i
//   found_o - high when any request is set
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    pick_o,
    output logic            found_o
);

    logic [PtrW-1:0] idx;

    always_comb begin
        pick_o  = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PtrW'((32'(ptr_i) + k) % N);
            if (!found_o && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/print_arbiter.sv
// Arbitrates whole messages from NREQ byte requesters onto one UART transmit stream.
//   usbclk, usbrst_n     - clock, asynchronous active-low reset
//   req_valid/data/last  - per-requester byte stream (requester i on req_data[8i+7:8i])
//   req_ready            - per-requester accept (only the owner, only in LOCK)
//   tx_valid/data/ready  - registered byte stream to the transmitter
//   grant                - one-hot current owner, zero when idle
//   busy                 - high in LOCK or DRAIN
//   timeout_err, err_clr - sticky per-requester timeout flags and their clear
module print_arbiter
    import print_arb_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              usbclk,
    input  logic              usbrst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [NREQ-1:0]   timeout_err,
    input  logic              err_clr
);

    localparam int unsigned      PtrW       = $clog2(NREQ);
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    arb_state_e       state_q;
    logic [NREQ-1:0]  grant_q;
    logic [PtrW-1:0]  rr_ptr_q;
    logic             tx_valid_q;
    logic [7:0]       tx_data_q;
    logic             busy_q;
    logic [NREQ-1:0]  timeout_err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [NREQ-1:0]  pick;
    logic             found;
    logic [7:0]       own_data;
    logic [PtrW-1:0]  own_idx;
    logic [PtrW-1:0]  next_ptr;
    logic             own_valid;
    logic             own_last;
    logic             slot_free;
    logic             accept;
    logic             tx_hs;
    logic             timeout_hit;
    logic [NREQ-1:0]  timeout_err_d;

    rr_pick #(
        .N    (NREQ),
        .PtrW (PtrW)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .pick_o  (pick),
        .found_o (found)
    );

    // Owner's byte and index, decoded from the one-hot grant.
    always_comb begin
        own_data = '0;
        own_idx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                own_data = req_data[8*i +: 8];
                own_idx  = PtrW'(i);
            end
        end
    end

    assign own_valid = |(req_valid & grant_q);
    assign own_last  = |(req_last & grant_q);
    // The output register can take a byte when empty or being emptied this cycle.
    assign slot_free = !tx_valid_q || tx_ready;
    assign req_ready = (state_q == StLock && slot_free) ? grant_q : '0;
    assign accept    = (state_q == StLock) && slot_free && own_valid;
    assign tx_hs     = tx_valid_q && tx_ready;
    assign timeout_hit = (state_q == StLock) && !accept && (cnt_q == TimeoutCnt);
    assign next_ptr  = (own_idx == PtrW'(NREQ - 1)) ? '0 : own_idx + PtrW'(1);
    // A timeout set in the same cycle as err_clr wins for its bit.
    assign timeout_err_d = (timeout_err_q & ~{NREQ{err_clr}}) | (timeout_hit ? grant_q : '0);

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= '0;
            cnt_q         <= '0;
        end else begin
            timeout_err_q <= timeout_err_d;

            if (accept) begin
                tx_data_q  <= own_data;
                tx_valid_q <= 1'b1;
            end else if (tx_hs) begin
                tx_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        grant_q <= pick;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StLock;
                    end
                end
                StLock: begin
                    if (accept) begin
                        cnt_q <= '0;
                        if (own_last) begin
                            rr_ptr_q <= next_ptr;
                            state_q  <= StDrain;
                        end
                    end else if (timeout_hit) begin
                        rr_ptr_q <= next_ptr;
                        if (tx_valid_q) begin
                            state_q <= StDrain;
                        end else begin
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else if (!own_valid) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDrain: begin
                    // Also leaves when the register already emptied on the entry edge.
                    if (slot_free) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_print_arbiter.sv
// Scoreboard bench for print_arbiter (NREQ=4, TIMEOUT=16).
module tb_print_arbiter;

    logic        usbclk = 1'b0;
    logic        usbrst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  timeout_err;
    logic        err_clr;

    print_arbiter #(
        .NREQ    (4),
        .TIMEOUT (16)
    ) dut (
        .usbclk      (usbclk),
        .usbrst_n    (usbrst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 usbclk = ~usbclk;

    int n_chk = 0;
    int n_bad = 0;

    // Per-requester byte sources: {last, data}.
    logic [8:0]  src_mem [4][16];
    int          src_rd  [4];
    int          src_wr  [4];
    // Expected transmit stream: {owner one-hot, data}.
    logic [11:0] exp_q [$];
    logic [3:0]  acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge usbclk);
    endtask

    task automatic send(input int r, input logic [7:0] d, input logic last);
        src_mem[r][src_wr[r]] = {last, d};
        src_wr[r]++;
        exp_q.push_back({4'(1 << r), d});
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || tx_valid) && n < 300) begin
            step(1);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_txv"}, 32'(tx_valid), 32'd0);
        check({tag, "_txd"}, 32'(tx_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_rdy"}, 32'(req_ready), 32'd0);
    endtask

    // Requester sources and transmit monitor.
    initial begin : drv
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge usbclk);
            acc = req_valid & req_ready;
            if (usbrst_n && tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("tx_extra", 32'(exp_q.size()), 32'd1);
                else check("tx_byte", {20'd0, grant, tx_data}, {20'd0, exp_q.pop_front()});
            end
            @(posedge usbclk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) src_rd[i]++;
                if (src_rd[i] < src_wr[i]) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = src_mem[i][src_rd[i]][7:0];
                    req_last[i]         = src_mem[i][src_rd[i]][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1);
    end

    initial begin : main
        for (int i = 0; i < 4; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        usbrst_n = 1'b0;
        tx_ready = 1'b1;
        err_clr  = 1'b0;
        #1;
        check_all_zero("reset");
        step(3);
        usbrst_n = 1'b1;
        step(1);

        // Two requesters from rr_ptr=0: owner 1 sends "AB", then owner 2.
        send(1, 8'h41, 1'b0);
        send(1, 8'h42, 1'b1);
        send(2, 8'h5A, 1'b1);
        step(1);
        check("s1_t_grant", 32'(grant), 32'd0);
        step(1);
        check("s1_t1_grant", 32'(grant), 32'h2);
        check("s1_t1_ready", 32'(req_ready), 32'h2);
        check("s1_t1_txv", 32'(tx_valid), 32'd0);
        step(1);
        check("s1_t2_txv", 32'(tx_valid), 32'd1);
        check("s1_t2_txd", 32'(tx_data), 32'h41);
        check("s1_t2_busy", 32'(busy), 32'd1);
        wait_idle("s1_done");

        // Five bytes with a three-cycle transmitter stall on byte 1.
        for (int k = 0; k < 5; k++) send(0, 8'(8'h10 + k), k == 4);
        @(posedge usbclk);
        #2;
        repeat (3) @(posedge usbclk);
        #2;
        tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("s2_stall_txv", 32'(tx_valid), 32'd1);
            check("s2_stall_txd", 32'(tx_data), 32'h11);
            check("s2_stall_rdy", 32'(req_ready), 32'd0);
        end
        @(posedge usbclk);
        #2;
        tx_ready = 1'b1;
        wait_idle("s2_done");

        // Owner 3 goes quiet after one byte; requester 0 waits behind it.
        send(3, 8'h30, 1'b0);
        send(0, 8'h01, 1'b1);
        step(1);
        step(5);
        check("s3_grant", 32'(grant), 32'h8);
        check("s3_ready", 32'(req_ready), 32'h8);
        check("s3_busy", 32'(busy), 32'd1);
        step(13);
        check("s3_err_early", 32'(timeout_err), 32'd0);
        step(1);
        check("s3_err_set", 32'(timeout_err), 32'h8);
        check("s3_released", 32'(grant), 32'd0);
        step(1);
        check("s3_next_grant", 32'(grant), 32'h1);
        wait_idle("s3_done");

        // Owner 2 times out; err_clr alone clears, err_clr on the timeout cycle loses.
        send(2, 8'h20, 1'b0);
        step(1);
        step(9);
        @(posedge usbclk);
        #2;
        err_clr = 1'b1;
        @(posedge usbclk);
        #2;
        err_clr = 1'b0;
        step(1);
        check("s4_clr", 32'(timeout_err), 32'd0);
        step(6);
        @(posedge usbclk);
        #2;
        err_clr = 1'b1;
        step(1);
        check("s4_pre", 32'(timeout_err), 32'd0);
        @(posedge usbclk);
        #2;
        err_clr = 1'b0;
        step(1);
        check("s4_set_wins", 32'(timeout_err), 32'h4);
        wait_idle("s4_done");

        // Reset while byte 1 of a four-byte message is in the transmit register.
        for (int k = 0; k < 4; k++) send(1, 8'(8'h61 + k), k == 3);
        step(1);
        step(1);
        @(posedge usbclk);
        #3;
        check("s5_inflight", 32'(tx_valid), 32'd1);
        usbrst_n = 1'b0;
        #1;
        check_all_zero("s5_async");
        for (int i = 0; i < 4; i++) src_rd[i] = src_wr[i];
        exp_q.delete();
        step(2);
        usbrst_n = 1'b1;
        step(1);
        send(1, 8'h51, 1'b1);
        send(3, 8'h73, 1'b1);
        step(2);
        check("s5_ptr_reset", 32'(grant), 32'h2);
        wait_idle("s5_done");

        // All four requesters busy with one-byte messages: strict rotation.
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 4; r++) send(r, 8'(8'h80 + 16 * m + r), 1'b1);
        end
        wait_idle("s6_done");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/print_arbiter.md
PRINT_ARBITER -- requirements
Module: print_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of message requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 65535: idle cycles allowed to a granted requester before forced release.
REQ-003 The block SHALL have port usbclk  in  1: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port usbrst_n  in  1: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  in  NREQ: per-requester byte valid.
REQ-006 The block SHALL have port req_data  in  NREQ*8: per-requester byte, requester i on bits [8i+7:8i].
REQ-007 The block SHALL have port req_last  in  NREQ: marks the final byte of a message.
REQ-008 The block SHALL have port req_ready  out  NREQ: byte accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 The block SHALL have port tx_valid  out  1: byte available to the UART transmitter.
REQ-010 The block SHALL have port tx_data  out  8: byte to the UART transmitter.
REQ-011 The block SHALL have port tx_ready  in  1: the transmitter takes the byte when tx_valid and tx_ready are both high.
REQ-012 The block SHALL have port grant  out  NREQ: one-hot current owner, all-zero when idle.
REQ-013 The block SHALL have port busy  out  1: high in LOCK or DRAIN.
REQ-014 The block SHALL have port timeout_err  out  NREQ: sticky per-requester timeout flag.
REQ-015 The block SHALL have port err_clr  in  1: clears all of timeout_err.

Function
REQ-016 The FSM SHALL have states IDLE, LOCK and DRAIN.
REQ-017 IDLE: when any req_valid is high, the block SHALL pick the first requester at or after rr_ptr (wrapping NREQ-1 -> 0), register it in grant and enter LOCK the next cycle.
REQ-018 Latency SHALL be: req_valid high in IDLE at cycle t -> grant and req_ready at t+1 -> tx_valid at t+2.
REQ-019 LOCK: req_ready[g] SHALL equal (!tx_valid | tx_ready); req_ready for all non-owners SHALL be 0.
REQ-020 On an accepted byte, tx_data SHALL load req_data[g] and tx_valid SHALL be 1 the next cycle; tx_valid SHALL clear after a tx handshake with no new byte accepted.
REQ-021 Full throughput SHALL be one byte per cycle when tx_ready stays high.
REQ-022 A message SHALL be atomic: no other requester is granted until the owner's req_last byte is accepted or the timeout fires.
REQ-023 On acceptance of a req_last byte the FSM SHALL enter DRAIN.
REQ-024 DRAIN SHALL hold grant, keep every req_ready at 0, and go to IDLE on the tx handshake.
REQ-025 On each release, rr_ptr SHALL become (g+1) mod NREQ.
REQ-026 The timeout counter SHALL be 17 bits wide, clear on entry to LOCK and on every accepted byte, and count while req_valid[g] is 0.
REQ-027 When the timeout counter equals TIMEOUT, the block SHALL set timeout_err[g] and release: to DRAIN if tx_valid is high, else to IDLE.
REQ-028 When err_clr and a new timeout occur in the same cycle, the set SHALL win for that bit.
REQ-029 tx_valid SHALL NOT drop and tx_data SHALL NOT change while tx_ready is low.
REQ-030 A requester deasserting req_valid mid-message SHALL keep the grant until timeout.
REQ-031 Changes on non-owner inputs SHALL have no effect.
REQ-032 All outputs SHALL be registered, except req_ready.

Reset
REQ-033 While usbrst_n is low, regardless of clock: state SHALL be IDLE, grant 0, rr_ptr 0, tx_valid 0, tx_data 0, busy 0, timeout_err 0, counter 0, req_ready 0.
REQ-034 Reset mid-message SHALL discard any pending tx byte, and no partial message SHALL resume after reset.

Structure
REQ-035 Package print_arb_pkg SHALL hold the state enum, NREQ_DEFAULT and TIMEOUT_DEFAULT.
REQ-036 Sub-module rr_pick SHALL be combinational: req vector and pointer -> one-hot pick plus a found flag.
REQ-037 A single clocked process SHALL cover the FSM, data register and counter.

Verification
REQ-038 With req_valid=4'b0110 in IDLE at rr_ptr=0 and message "AB" on requester 1, the bench SHALL see grant=4'b0010 at t+1, tx bytes 0x41 then 0x42, then IDLE, then grant=4'b0100 with rr_ptr=2.
REQ-039 With requester 0 sending 5 bytes and tx_ready held low for 3 cycles mid-message, the bench SHALL see tx_data stable, req_ready[0]=0 throughout the stall, and 5 bytes delivered in order.
REQ-040 With requester 3 granted and then req_valid[3] dropped with TIMEOUT=16, the bench SHALL see timeout_err=4'b1000 after 16 idle cycles, a release, and requester 0 served next.
REQ-041 With err_clr pulsed in the same cycle as a timeout on requester 2, the bench SHALL see timeout_err[2]=1 and all other bits 0.
REQ-042 With usbrst_n asserted during byte 2 of a 4-byte message, the bench SHALL see all outputs 0 immediately (asynchronous), and after release the next grant chosen from rr_ptr=0.
REQ-043 With all 4 requesters continuously sending 1-byte messages, the bench SHALL see grants rotate 0,1,2,3,0 with no starvation.
